// File: rtl/vga_buffer_pkg.sv
// Shared geometry, field widths and controller state encoding for the VGA frame
// buffer write/read address generation.
package vga_buffer_pkg;

   localparam int H_PIX = 320;
   localparam int V_PIX = 240;
   localparam int ROW_W = 8;
   localparam int COL_W = 9;
   localparam int PIX_W = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      CLEAR  = 2'd2
   } state_t;

endpackage

// File: rtl/raster_counter.sv
// Row/column raster position counter. Clear returns to the origin; clear together
// with advance lands on (0,1) so a frame restart can consume its own pixel.
module raster_counter
   import vga_buffer_pkg::*;
#(
   parameter int H_PIX = vga_buffer_pkg::H_PIX,
   parameter int V_PIX = vga_buffer_pkg::V_PIX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             advance,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic             last
);

   logic row_end_s;
   logic col_end_s;

   // End-of-row / end-of-frame detection from the current position
   always_comb begin
      row_end_s = (row == ROW_W'(V_PIX - 1));
      col_end_s = (col == COL_W'(H_PIX - 1));
      last      = row_end_s & col_end_s;
   end

   // Position register with raster-order wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= advance ? COL_W'(1) : COL_W'(0);
      end else if (advance) begin
         if (col_end_s) begin
            col <= '0;
            row <= row_end_s ? ROW_W'(0) : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

endmodule

// File: rtl/vga_buffer_ctrl.sv
// Frame buffer controller: places an incoming pixel stream or a fill colour into
// raster addresses, and keeps an independent display read address.
module vga_buffer_ctrl
   import vga_buffer_pkg::*;
#(
   parameter int H_PIX = vga_buffer_pkg::H_PIX,
   parameter int V_PIX = vga_buffer_pkg::V_PIX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic             in_sof,
   input  logic             clear_start,
   input  logic [PIX_W-1:0] clear_color,
   output logic             wr_en,
   output logic [PIX_W-1:0] wr_pixel,
   output logic [ROW_W-1:0] wr_row,
   output logic [COL_W-1:0] wr_col,
   input  logic             rd_req,
   input  logic             rd_sof,
   output logic [ROW_W-1:0] rd_row,
   output logic [COL_W-1:0] rd_col,
   output logic             frame_done,
   output logic             clear_done,
   output logic             sof_err,
   output logic             busy
);

   state_t           state_r;
   logic             ready_r;
   logic [PIX_W-1:0] clr_color_r;
   logic             accept_s;
   logic             wc_clear_s;
   logic             wc_adv_s;
   logic [ROW_W-1:0] wc_row_s;
   logic [COL_W-1:0] wc_col_s;
   logic             wc_last_s;
   logic             rd_adv_s;
   logic             rd_last_unused_s;

   // A pending fill request in IDLE takes the cycle, so the stream is held off
   always_comb begin
      in_ready = ready_r & ~((state_r == IDLE) & clear_start);
      accept_s = in_valid & in_ready;
      busy     = (state_r != IDLE);
      rd_adv_s = rd_req & ~rd_sof;
   end

   // Write-address counter steering for each state
   always_comb begin
      wc_clear_s = 1'b0;
      wc_adv_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (clear_start) begin
               wc_clear_s = 1'b1;
            end else if (accept_s & in_sof) begin
               wc_clear_s = 1'b1;
               wc_adv_s   = 1'b1;
            end else begin
               wc_clear_s = 1'b0;
            end
         end
         STREAM: begin
            if (accept_s & in_sof) begin
               wc_clear_s = 1'b1;
               wc_adv_s   = 1'b1;
            end else if (accept_s & wc_last_s) begin
               wc_clear_s = 1'b1;
            end else if (accept_s) begin
               wc_adv_s = 1'b1;
            end else begin
               wc_adv_s = 1'b0;
            end
         end
         CLEAR: begin
            if (wc_last_s) begin
               wc_clear_s = 1'b1;
            end else begin
               wc_adv_s = 1'b1;
            end
         end
         default: begin
            wc_clear_s = 1'b1;
         end
      endcase
   end

   raster_counter #(
      .H_PIX (H_PIX),
      .V_PIX (V_PIX)
   ) u_wr_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (wc_clear_s),
      .advance (wc_adv_s),
      .row     (wc_row_s),
      .col     (wc_col_s),
      .last    (wc_last_s)
   );

   raster_counter #(
      .H_PIX (H_PIX),
      .V_PIX (V_PIX)
   ) u_rd_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (rd_sof),
      .advance (rd_adv_s),
      .row     (rd_row),
      .col     (rd_col),
      .last    (rd_last_unused_s)
   );

   // Controller FSM with registered write port and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         ready_r     <= 1'b0;
         clr_color_r <= '0;
         wr_en       <= 1'b0;
         wr_pixel    <= '0;
         wr_row      <= '0;
         wr_col      <= '0;
         frame_done  <= 1'b0;
         clear_done  <= 1'b0;
         sof_err     <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         clear_done <= 1'b0;
         sof_err    <= 1'b0;
         case (state_r)
            IDLE: begin
               ready_r <= 1'b1;
               if (clear_start) begin
                  clr_color_r <= clear_color;
                  ready_r     <= 1'b0;
                  state_r     <= CLEAR;
               end else if (accept_s & in_sof) begin
                  wr_en    <= 1'b1;
                  wr_pixel <= in_pixel;
                  wr_row   <= '0;
                  wr_col   <= '0;
                  state_r  <= STREAM;
               end else if (accept_s) begin
                  sof_err <= 1'b1;
               end
            end
            STREAM: begin
               ready_r <= 1'b1;
               if (accept_s & in_sof) begin
                  sof_err  <= 1'b1;
                  wr_en    <= 1'b1;
                  wr_pixel <= in_pixel;
                  wr_row   <= '0;
                  wr_col   <= '0;
               end else if (accept_s) begin
                  wr_en    <= 1'b1;
                  wr_pixel <= in_pixel;
                  wr_row   <= wc_row_s;
                  wr_col   <= wc_col_s;
                  if (wc_last_s) begin
                     frame_done <= 1'b1;
                     state_r    <= IDLE;
                  end
               end
            end
            CLEAR: begin
               wr_en    <= 1'b1;
               wr_pixel <= clr_color_r;
               wr_row   <= wc_row_s;
               wr_col   <= wc_col_s;
               if (wc_last_s) begin
                  clear_done <= 1'b1;
                  ready_r    <= 1'b1;
                  state_r    <= IDLE;
               end
            end
            default: begin
               ready_r <= 1'b1;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_buffer_ctrl.sv
// Directed bench for vga_buffer_ctrl on a reduced 20x12 raster so that every
// frame-level scenario (stream, fill, read walk, reset) runs end to end.
module tb_vga_buffer_ctrl;

   localparam int H = 20;
   localparam int V = 12;
   localparam int N = H * V;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] in_pixel = 12'h000;
   logic        in_sof = 1'b0;
   logic        clear_start = 1'b0;
   logic [11:0] clear_color = 12'h000;
   logic        wr_en;
   logic [11:0] wr_pixel;
   logic [7:0]  wr_row;
   logic [8:0]  wr_col;
   logic        rd_req = 1'b0;
   logic        rd_sof = 1'b0;
   logic [7:0]  rd_row;
   logic [8:0]  rd_col;
   logic        frame_done;
   logic        clear_done;
   logic        sof_err;
   logic        busy;

   int total = 0;
   int bad = 0;

   vga_buffer_ctrl #(.H_PIX(H), .V_PIX(V)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_pixel(in_pixel), .in_sof(in_sof), .clear_start(clear_start),
      .clear_color(clear_color), .wr_en(wr_en), .wr_pixel(wr_pixel),
      .wr_row(wr_row), .wr_col(wr_col), .rd_req(rd_req), .rd_sof(rd_sof),
      .rd_row(rd_row), .rd_col(rd_col), .frame_done(frame_done),
      .clear_done(clear_done), .sof_err(sof_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        sof;
      logic [11:0] pix;
      logic        rreq;
      logic        rsof;
      logic        e_wen;
      logic [11:0] e_pix;
      logic [7:0]  e_row;
      logic [8:0]  e_col;
      logic        e_err;
      logic        e_busy;
      logic [7:0]  e_rrow;
      logic [8:0]  e_rcol;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_write(input string nm, input logic [11:0] pix, input int pos);
      chk({nm, " wr_en"}, 32'(wr_en), 32'd1);
      chk({nm, " wr_pixel"}, 32'(wr_pixel), 32'(pix));
      chk({nm, " wr_row"}, 32'(wr_row), 32'(pos / H));
      chk({nm, " wr_col"}, 32'(wr_col), 32'(pos % H));
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, " in_ready"}, 32'(in_ready), 32'd0);
      chk({nm, " wr_en"}, 32'(wr_en), 32'd0);
      chk({nm, " wr_pixel"}, 32'(wr_pixel), 32'd0);
      chk({nm, " wr_addr"}, {15'd0, wr_row, wr_col}, 32'd0);
      chk({nm, " rd_addr"}, {15'd0, rd_row, rd_col}, 32'd0);
      chk({nm, " pulses"}, {29'd0, frame_done, clear_done, sof_err}, 32'd0);
      chk({nm, " busy"}, 32'(busy), 32'd0);
   endtask

   task automatic drive(input logic v, input logic s, input logic [11:0] p);
      in_valid = v;
      in_sof   = s;
      in_pixel = p;
   endtask

   initial begin
      // idle/stream entry, sof handling and read counter in short steps
      vecs[0] = '{1'b1, 1'b0, 12'hAAA, 1'b0, 1'b0, 1'b0, 12'h000, 8'd0, 9'd0, 1'b1, 1'b0, 8'd0, 9'd0};
      vecs[1] = '{1'b1, 1'b1, 12'hBBB, 1'b1, 1'b0, 1'b1, 12'hBBB, 8'd0, 9'd0, 1'b0, 1'b1, 8'd0, 9'd1};
      vecs[2] = '{1'b1, 1'b0, 12'h001, 1'b1, 1'b0, 1'b1, 12'h001, 8'd0, 9'd1, 1'b0, 1'b1, 8'd0, 9'd2};
      vecs[3] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000, 8'd0, 9'd0, 1'b0, 1'b1, 8'd0, 9'd0};
      vecs[4] = '{1'b1, 1'b0, 12'h002, 1'b1, 1'b1, 1'b1, 12'h002, 8'd0, 9'd2, 1'b0, 1'b1, 8'd0, 9'd0};
      vecs[5] = '{1'b1, 1'b1, 12'h123, 1'b1, 1'b0, 1'b1, 12'h123, 8'd0, 9'd0, 1'b1, 1'b1, 8'd0, 9'd1};
      vecs[6] = '{1'b1, 1'b0, 12'h124, 1'b0, 1'b0, 1'b1, 12'h124, 8'd0, 9'd1, 1'b0, 1'b1, 8'd0, 9'd1};

      step();
      step();
      check_all_zero("reset");
      rst_n = 1'b1;
      step();
      chk("post-reset in_ready", 32'(in_ready), 32'd1);
      chk("post-reset busy", 32'(busy), 32'd0);

      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].v, vecs[i].sof, vecs[i].pix);
         rd_req = vecs[i].rreq;
         rd_sof = vecs[i].rsof;
         #1;
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
         step();
         chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vecs[i].e_wen));
         if (vecs[i].e_wen) begin
            chk($sformatf("vec%0d wr_pixel", i), 32'(wr_pixel), 32'(vecs[i].e_pix));
            chk($sformatf("vec%0d wr_row", i), 32'(wr_row), 32'(vecs[i].e_row));
            chk($sformatf("vec%0d wr_col", i), 32'(wr_col), 32'(vecs[i].e_col));
         end
         chk($sformatf("vec%0d sof_err", i), 32'(sof_err), 32'(vecs[i].e_err));
         chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
         chk($sformatf("vec%0d rd_row", i), 32'(rd_row), 32'(vecs[i].e_rrow));
         chk($sformatf("vec%0d rd_col", i), 32'(rd_col), 32'(vecs[i].e_rcol));
      end
      rd_req = 1'b0;
      rd_sof = 1'b0;

      // stream on to (5,10), then a stray sof restarts the frame
      for (int p = 2; p < 5 * H + 10; p++) begin
         drive(1'b1, 1'b0, 12'(p));
         step();
         check_write("midrow", 12'(p), p);
         chk("midrow sof_err", 32'(sof_err), 32'd0);
      end
      drive(1'b1, 1'b1, 12'h5A5);
      step();
      check_write("stray sof", 12'h5A5, 0);
      chk("stray sof_err", 32'(sof_err), 32'd1);
      drive(1'b1, 1'b0, 12'h5A6);
      step();
      check_write("after stray", 12'h5A6, 1);
      chk("after stray sof_err", 32'(sof_err), 32'd0);

      // full frame, pixel value = index; sof arrives while still streaming
      for (int i = 0; i < N; i++) begin
         drive(1'b1, (i == 0), 12'(i % 4096));
         #1;
         chk("frame in_ready", 32'(in_ready), 32'd1);
         step();
         check_write("frame", 12'(i % 4096), i);
         chk("frame frame_done", 32'(frame_done), 32'(i == N - 1));
         chk("frame sof_err", 32'(sof_err), 32'(i == 0));
      end
      drive(1'b0, 1'b0, 12'h000);
      step();
      chk("frame end wr_en", 32'(wr_en), 32'd0);
      chk("frame end frame_done", 32'(frame_done), 32'd0);
      chk("frame end busy", 32'(busy), 32'd0);

      // fill: clear_start wins over a simultaneous sof transfer
      drive(1'b1, 1'b1, 12'h555);
      clear_start = 1'b1;
      clear_color = 12'h0F0;
      #1;
      chk("clear start in_ready", 32'(in_ready), 32'd0);
      step();
      clear_start = 1'b0;
      clear_color = 12'h000;
      chk("clear entry wr_en", 32'(wr_en), 32'd0);
      chk("clear entry in_ready", 32'(in_ready), 32'd0);
      chk("clear entry busy", 32'(busy), 32'd1);
      for (int k = 1; k <= N; k++) begin
         clear_start = (k == N / 2);
         clear_color = (k == N / 2) ? 12'hF00 : 12'h000;
         step();
         check_write("clear", 12'h0F0, k - 1);
         chk("clear clear_done", 32'(clear_done), 32'(k == N));
         chk("clear in_ready", 32'(in_ready), 32'(k == N));
         chk("clear sof_err", 32'(sof_err), 32'd0);
      end
      clear_start = 1'b0;
      drive(1'b0, 1'b0, 12'h000);
      step();
      chk("clear end wr_en", 32'(wr_en), 32'd0);
      chk("clear end clear_done", 32'(clear_done), 32'd0);
      chk("clear end busy", 32'(busy), 32'd0);

      // read address walks the whole raster and wraps to the origin
      rd_sof = 1'b1;
      step();
      rd_sof = 1'b0;
      chk("rd restart", {15'd0, rd_row, rd_col}, 32'd0);
      rd_req = 1'b1;
      for (int j = 1; j <= N; j++) begin
         step();
         chk("rd walk row", 32'(rd_row), 32'((j % N) / H));
         chk("rd walk col", 32'(rd_col), 32'((j % N) % H));
      end
      step();
      step();
      rd_sof = 1'b1;
      step();
      chk("rd sof+req", {15'd0, rd_row, rd_col}, 32'd0);
      rd_sof = 1'b0;
      rd_req = 1'b0;

      // reset half-way through a frame abandons it silently
      rd_req = 1'b1;
      for (int i = 0; i < (V / 2) * H; i++) begin
         drive(1'b1, (i == 0), 12'(i));
         step();
         chk("pre-reset frame_done", 32'(frame_done), 32'd0);
      end
      chk("pre-reset busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      drive(1'b0, 1'b0, 12'h000);
      rd_req = 1'b0;
      step();
      step();
      check_all_zero("midreset hold");
      rst_n = 1'b1;
      step();
      chk("recover in_ready", 32'(in_ready), 32'd1);
      chk("recover frame_done", 32'(frame_done), 32'd0);
      chk("recover busy", 32'(busy), 32'd0);
      drive(1'b1, 1'b1, 12'h777);
      step();
      check_write("recover sof", 12'h777, 0);
      chk("recover sof_err", 32'(sof_err), 32'd0);
      drive(1'b1, 1'b0, 12'h778);
      step();
      check_write("recover next", 12'h778, 1);
      chk("recover next frame_done", 32'(frame_done), 32'd0);
      drive(1'b0, 1'b0, 12'h000);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
